// File: rtl/bilinear_scaler_stream_pkg.sv
// Shared definitions for the bilinear scaler.
// Holds the frame FSM state encoding, the default fixed-point precision, and
// the width helpers used to size coordinate and address ports.
package bilinear_scaler_stream_pkg;

    localparam int PREC_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        COORD,
        FETCH,
        WAIT,
        CALC,
        OUT,
        DONE
    } state_e;

    // One extra bit so the maximum dimension itself is representable.
    function automatic int calc_xw(input int max_w);
        return $clog2(max_w) + 1;
    endfunction

    function automatic int calc_yw(input int max_h);
        return $clog2(max_h) + 1;
    endfunction

    function automatic int calc_aw(input int max_w, input int max_h, input int channel);
        return $clog2(max_w * max_h * channel);
    endfunction

endpackage

// File: rtl/bilinear_scaler_stream_if.sv
// Bus bundle between the scaler and its surroundings.
// Source memory side: mem_rd / mem_addr out, mem_rdata back one cycle later.
// Output stream side: out_valid / out_data / out_last out, out_ready back.
// master = scaler, slave = memory + sink.
interface bilinear_scaler_stream_if
    import bilinear_scaler_stream_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int AW    = calc_aw(64, 64, 3)
);
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output mem_rd, mem_addr, out_valid, out_data, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/bilinear_scaler_stream_seq_div.sv
// Restoring divider computing q = floor((a << P) / b).
// Ports: clk, rst (sync, active-high), start (loads operands), a, b,
//        done (high from the end of the run until the next start), q.
// Latency is fixed: done rises IN_W+P+1 cycles after the start cycle.
// b is assumed non-zero; the caller validates it beforehand.
module seq_div #(
    parameter int IN_W = 7,
    parameter int P    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_W-1:0]     a,
    input  logic [IN_W-1:0]     b,
    output logic                done,
    output logic [IN_W+P-1:0]   q
);
    localparam int NW   = IN_W + P;
    localparam int CNTW = $clog2(NW + 1);

    logic [NW-1:0]   num_q, num_d;
    logic [NW-1:0]   quo_q, quo_d;
    logic [IN_W-1:0] rem_q, rem_d;
    logic [IN_W-1:0] den_q, den_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;
    // Partial remainder with the next numerator bit shifted in; it is always
    // below 2*den, so one extra bit over the divisor width is enough.
    logic [IN_W:0]   trial;

    always_comb begin
        num_d  = num_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = done_q;
        trial  = {rem_q, num_q[NW-1]};
        if (start) begin
            num_d  = {a, {P{1'b0}}};
            quo_d  = '0;
            rem_d  = '0;
            den_d  = b;
            cnt_d  = CNTW'(NW);
            run_d  = 1'b1;
            done_d = 1'b0;
        end else if (run_q) begin
            num_d = {num_q[NW-2:0], 1'b0};
            if (trial >= {1'b0, den_q}) begin
                rem_d = IN_W'(trial - {1'b0, den_q});
                quo_d = {quo_q[NW-2:0], 1'b1};
            end else begin
                rem_d = IN_W'(trial);
                quo_d = {quo_q[NW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        num_q <= num_d;
        quo_q <= quo_d;
        rem_q <= rem_d;
        den_q <= den_d;
    end

    assign done = done_q;
    assign q    = quo_q;

endmodule

// File: rtl/bilinear_scaler_stream.sv
// Runtime-configurable bilinear scaler (up or down), 1..CHANNEL channels.
// Ports: clk, rst (sync, active-high); start + cfg_w_in/h_in/w_out/h_out
//        (sampled on an accepted start); busy, done (1-cycle pulse), err
//        (bad config, valid with done, held until next start); bus carries
//        the source-memory read port and the output sample stream.
// Each output sample takes COORD (first channel only), 4 FETCH reads,
// WAIT, CALC and OUT, so out_valid follows the first read by 6 cycles.
module bilinear_scaler_stream
    import bilinear_scaler_stream_pkg::*;
#(
    parameter int  MAX_W   = 64,
    parameter int  MAX_H   = 64,
    parameter int  CHANNEL = 3,
    parameter int  PIX_W   = 8,
    parameter int  PREC    = PREC_DEF,
    localparam int XW      = calc_xw(MAX_W),
    localparam int YW      = calc_yw(MAX_H),
    localparam int AW      = calc_aw(MAX_W, MAX_H, CHANNEL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] cfg_w_in,
    input  logic [YW-1:0] cfg_h_in,
    input  logic [XW-1:0] cfg_w_out,
    input  logic [YW-1:0] cfg_h_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    bilinear_scaler_stream_if.master bus
);
    localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    // Weighted sum width: weight product needs 2*PREC+1 bits, times a sample,
    // plus two bits of headroom for the four-term accumulation.
    localparam int SW = 2 * PREC + PIX_W + 3;
    localparam logic [PREC:0] ONE = {1'b1, {PREC{1'b0}}};

    function automatic logic [PIX_W-1:0] round_sat(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = (s + (SW'(1) << (2 * PREC - 1))) >> (2 * PREC);
        if (r > SW'({PIX_W{1'b1}})) begin
            return {PIX_W{1'b1}};
        end
        return PIX_W'(r);
    endfunction

    state_e state_q, state_d;

    logic [XW-1:0]    w_in_q, w_in_d, w_out_q, w_out_d;
    logic [YW-1:0]    h_in_q, h_in_d, h_out_q, h_out_d;
    logic             err_q, err_d;
    logic [XW-1:0]    x_out_q, x_out_d;
    logic [YW-1:0]    y_out_q, y_out_d;
    logic [CW-1:0]    c_q, c_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic [1:0]       rd_sel_q, rd_sel_d;
    logic [XW-1:0]    x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0]    y0_q, y0_d, y1_q, y1_d;
    logic [PREC-1:0]  a_q, a_d, b_q, b_d;
    logic [AW-1:0]    row0_q, row0_d, row1_q, row1_d;
    logic [PIX_W-1:0] pix_q [4];
    logic [PIX_W-1:0] pix_d [4];
    logic [PIX_W-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic             cfg_ok;
    logic             div_start;
    logic             div_done_x, div_done_y;
    logic [XW+PREC-1:0] rw;
    logic [YW+PREC-1:0] rh;
    logic [XW+PREC-1:0] xi;
    logic [YW+PREC-1:0] yi;
    logic [XW-1:0]    x0_c, x1_c;
    logic [YW-1:0]    y0_c, y1_c;
    logic [AW-1:0]    pix_idx, rd_addr;
    logic [PREC:0]    wa, wna, wb, wnb;
    logic [SW-1:0]    sum;

    // Dividers are launched from the accepting IDLE cycle straight off the
    // cfg inputs, which are the same values captured into the cfg registers.
    seq_div #(.IN_W(XW), .P(PREC)) u_div_x (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (cfg_w_in),
        .b     (cfg_w_out),
        .done  (div_done_x),
        .q     (rw)
    );

    seq_div #(.IN_W(YW), .P(PREC)) u_div_y (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (cfg_h_in),
        .b     (cfg_h_out),
        .done  (div_done_y),
        .q     (rh)
    );

    assign cfg_ok = (cfg_w_in  != '0) && (cfg_w_in  <= XW'(MAX_W)) &&
                    (cfg_h_in  != '0) && (cfg_h_in  <= YW'(MAX_H)) &&
                    (cfg_w_out != '0) && (cfg_w_out <= XW'(MAX_W)) &&
                    (cfg_h_out != '0) && (cfg_h_out <= YW'(MAX_H));

    // Source coordinates. The product cannot overflow XW+PREC bits because
    // x_out*rW < w_in<<PREC, and floor keeps x0 inside the row.
    always_comb begin
        xi   = XW'(0) + (XW+PREC)'(x_out_q) * rw;
        yi   = (YW+PREC)'(y_out_q) * rh;
        x0_c = xi[XW+PREC-1:PREC];
        y0_c = yi[YW+PREC-1:PREC];
        x1_c = (x0_c == w_in_q - XW'(1)) ? x0_c : x0_c + XW'(1);
        y1_c = (y0_c == h_in_q - YW'(1)) ? y0_c : y0_c + YW'(1);
    end

    // Read order p00, p10, p01, p11 for the current channel.
    always_comb begin
        case (fcnt_q)
            2'd0:    pix_idx = row0_q + AW'(x0_q);
            2'd1:    pix_idx = row0_q + AW'(x1_q);
            2'd2:    pix_idx = row1_q + AW'(x0_q);
            default: pix_idx = row1_q + AW'(x1_q);
        endcase
        rd_addr = pix_idx * AW'(CHANNEL) + AW'(c_q);
    end

    always_comb begin
        wa  = {1'b0, a_q};
        wna = ONE - wa;
        wb  = {1'b0, b_q};
        wnb = ONE - wb;
        sum = SW'(wna) * SW'(wnb) * SW'(pix_q[0]) +
              SW'(wa)  * SW'(wnb) * SW'(pix_q[1]) +
              SW'(wna) * SW'(wb)  * SW'(pix_q[2]) +
              SW'(wa)  * SW'(wb)  * SW'(pix_q[3]);
    end

    always_comb begin
        state_d    = state_q;
        w_in_d     = w_in_q;
        h_in_d     = h_in_q;
        w_out_d    = w_out_q;
        h_out_d    = h_out_q;
        err_d      = err_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;
        c_d        = c_q;
        fcnt_d     = fcnt_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        a_d        = a_q;
        b_d        = b_q;
        row0_d     = row0_q;
        row1_d     = row1_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        div_start  = 1'b0;
        pix_d      = pix_q;
        // A read issued this cycle returns next cycle; remember its slot.
        rd_vld_d   = (state_q == FETCH);
        rd_sel_d   = fcnt_q;
        if (rd_vld_q) begin
            pix_d[rd_sel_q] = bus.mem_rdata;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_in_d  = cfg_w_in;
                    h_in_d  = cfg_h_in;
                    w_out_d = cfg_w_out;
                    h_out_d = cfg_h_out;
                    x_out_d = '0;
                    y_out_d = '0;
                    c_d     = '0;
                    err_d   = !cfg_ok;
                    if (cfg_ok) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DIV: begin
                if (div_done_x && div_done_y) begin
                    state_d = COORD;
                end
            end
            COORD: begin
                x0_d    = x0_c;
                x1_d    = x1_c;
                y0_d    = y0_c;
                y1_d    = y1_c;
                a_d     = xi[PREC-1:0];
                b_d     = yi[PREC-1:0];
                row0_d  = AW'(y0_c) * AW'(w_in_q);
                row1_d  = AW'(y1_c) * AW'(w_in_q);
                fcnt_d  = 2'd0;
                state_d = FETCH;
            end
            FETCH: begin
                fcnt_d = fcnt_q + 2'd1;
                if (fcnt_q == 2'd3) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = CALC;
            end
            CALC: begin
                out_data_d = round_sat(sum);
                out_last_d = (c_q == CW'(CHANNEL - 1)) &&
                             (x_out_q == w_out_q - XW'(1)) &&
                             (y_out_q == h_out_q - YW'(1));
                state_d    = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    fcnt_d = 2'd0;
                    if (c_q != CW'(CHANNEL - 1)) begin
                        c_d     = c_q + CW'(1);
                        state_d = FETCH;
                    end else begin
                        c_d = '0;
                        if (out_last_q) begin
                            state_d = DONE;
                        end else begin
                            if (x_out_q == w_out_q - XW'(1)) begin
                                x_out_d = '0;
                                y_out_d = y_out_q + YW'(1);
                            end else begin
                                x_out_d = x_out_q + XW'(1);
                            end
                            state_d = COORD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_q      <= 1'b0;
            x_out_q    <= '0;
            y_out_q    <= '0;
            c_q        <= '0;
            fcnt_q     <= '0;
            rd_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
            c_q        <= c_d;
            fcnt_q     <= fcnt_d;
            rd_vld_q   <= rd_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        w_in_q   <= w_in_d;
        h_in_q   <= h_in_d;
        w_out_q  <= w_out_d;
        h_out_q  <= h_out_d;
        rd_sel_q <= rd_sel_d;
        x0_q     <= x0_d;
        x1_q     <= x1_d;
        y0_q     <= y0_d;
        y1_q     <= y1_d;
        a_q      <= a_d;
        b_q      <= b_d;
        row0_q   <= row0_d;
        row1_q   <= row1_d;
        pix_q    <= pix_d;
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign bus.mem_rd    = (state_q == FETCH);
    assign bus.mem_addr  = (state_q == FETCH) ? rd_addr : '0;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: doc/bilinear_scaler_stream.md
Name: bilinear_scaler_stream

Overview:
- Runtime-configurable bilinear image scaler, up or down, with 1..CHANNEL channels.
- Reads source pixels from an external synchronous memory and emits output samples in raster order (x fastest, then y; channels innermost) on a valid/ready stream.
- Replaces the fixed-size, file-dumping scaler top. Adds runtime dimensions, edge clamping, rounding, backpressure and error reporting.

Parameters:
- MAX_W, 64, max input/output width
- MAX_H, 64, max input/output height
- CHANNEL, 3, channels per pixel (1..4)
- PIX_W, 8, bits per channel sample
- PREC, 8, fractional bits of fixed-point coordinates and weights
- Derived: XW=$clog2(MAX_W)+1, YW=$clog2(MAX_H)+1, AW=$clog2(MAX_W*MAX_H*CHANNEL)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle frame start request; ignored while busy
- cfg_w_in  in  XW  source width
- cfg_h_in  in  YW  source height
- cfg_w_out  in  XW  output width
- cfg_h_out  in  YW  output height
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- err  out  1  config invalid; valid with done, held until next start
- mem_rd  out  1  source read strobe
- mem_addr  out  AW  source address = (y*cfg_w_in + x)*CHANNEL + c
- mem_rdata  in  PIX_W  read data, exactly 1 cycle after mem_rd
- out_valid  out  1  output sample valid
- out_ready  in  1  sink accepts
- out_data  out  PIX_W  interpolated sample
- out_last  out  1  final sample of frame (last channel, last pixel)

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_last=0; FSM in IDLE.
- Reset mid-frame aborts immediately. No done pulse is produced.
- Configuration:
  - cfg_* is sampled into registers on the accepted start; later cfg changes are ignored.
  - Invalid config: any dimension is 0, or exceeds MAX_W/MAX_H.
  - Invalid config goes to DONE next cycle with err=1. No mem_rd is issued and out_valid stays 0.
- FSM states: IDLE, DIV, COORD, FETCH, WAIT, CALC, OUT, DONE.
  - IDLE -> DIV on start with valid config.
  - DIV computes rW = floor((w_in<<PREC)/w_out) and rH likewise, using two sequential dividers. Move to COORD when both signal done.
  - COORD registers:
    - xi = x_out*rW; x0 = xi>>PREC; a = xi[PREC-1:0]
    - x1 = min(x0+1, w_in-1)
    - y side likewise, giving y0, y1, b.
  - FETCH runs 4 cycles, one mem_rd per cycle in order p00(x0,y0), p10(x1,y0), p01(x0,y1), p11(x1,y1), for current channel c.
  - WAIT runs 1 cycle to capture p11.
  - CALC is 1 cycle:
    - sum = (2^PREC-a)(2^PREC-b)p00 + a(2^PREC-b)p10 + (2^PREC-a)b p01 + a*b*p11
    - out_data = (sum + 2^(2PREC-1)) >> 2PREC, saturated to 2^PIX_W-1.
  - OUT asserts out_valid.
- Timing:
  - out_valid rises 6 cycles after the first FETCH read of a sample.
  - out_data and out_last are held stable while out_valid && !out_ready.
- On handshake:
  - If c < CHANNEL-1: c++, go to FETCH (coordinates reused).
  - Otherwise: c=0 and advance x_out (wrap to 0, y_out++), go to COORD.
  - After the last sample (out_last handshake), go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- busy=1 in every state except IDLE.
- Arithmetic rules:
  - Products use full width (no truncation before the final shift).
  - Identity ratio (w_in == w_out) gives a=0, reproducing the source exactly.
  - Downscale gives ratio > 1.0. x0 <= w_in-1 is guaranteed by floor, and x1 is clamped.

Decomposition:
- Shared package: FSM state encoding, PREC, and the derived width functions XW/YW/AW.
- One sub-module: seq_div.
  - Restoring divider with start/done, computing (a<<P)/b.
  - Fixed latency IN_W+P+1 cycles. done is held until the next start.
  - Instantiated twice (x, y).

Test Plan:
- 2x2->4x4, CHANNEL=1, src {0,64,128,255} (row-major), out_ready=1:
  - out(0,0)=0, out(1,0)=32, out(3,0)=64 (edge clamp), out(1,1)=112.
  - 16 samples, out_last on 16th, then done pulse.
- 3x3->3x3, CHANNEL=3, random source -> output stream equals source bytes in order. mem reads are 4 per sample.
- 4x4->2x2, CHANNEL=1, src value = 16*y+x -> outputs {0,2,32,34} (rW=rH=512).
- Backpressure: out_ready low 5 cycles on sample 3 -> out_valid stays 1, out_data/out_last constant, no extra mem_rd, no sample lost or duplicated.
- cfg_w_out=0 plus start -> done and err both 1 within 2 cycles, mem_rd never asserted, out_valid 0. start during busy is ignored.
- rst asserted in the middle of FETCH -> next cycle all outputs at reset values. A new start then produces a correct full frame.
